us_multi_range_ctrl: RTL and testbench

US_MULTI_RANGE_CTRL -- requirements
Module: us_multi_range_ctrl

---
 rtl/us_range_pkg.sv | 24 ++
 rtl/us_echo_sync.sv | 22 ++
 rtl/us_multi_range_ctrl.sv | 116 +++++++++++
 tb/tb_us_multi_range_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/us_range_pkg.sv
// Shared state encodings and default timing constants for the multi-channel
// ultrasonic ranging controller.
package us_range_pkg;

  typedef enum logic [1:0] {
    WARM_UP = 2'b00,
    TRIGGER = 2'b01,
    MEASURE = 2'b10,
    REPORT  = 2'b11
  } range_state_t;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_WARM_CYC = 50;
  localparam int DEF_TRIG_CYC = 500;
  localparam int DEF_MEAS_CYC = 50000;
  localparam int DEF_THRESH   = 29410;
  localparam int DEF_CNT_W    = 22;

  // A single channel still needs a one-bit channel id.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/us_echo_sync.sv
// Two-flop synchroniser that brings one asynchronous echo line into the
// system clock domain.
module us_echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/us_multi_range_ctrl.sv
// Round-robin ultrasonic ranging controller: warms up, fires one trigger,
// counts echo-high clocks over a fixed window and reports one channel at a time.
module us_multi_range_ctrl
  import us_range_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int WARM_CYC = DEF_WARM_CYC,
  parameter int TRIG_CYC = DEF_TRIG_CYC,
  parameter int MEAS_CYC = DEF_MEAS_CYC,
  parameter int THRESH   = DEF_THRESH,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                          clk_50M,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             echo_rx,
  output logic [NUM_CH-1:0]             trigger,
  output logic [NUM_CH-1:0]             out,
  output logic [CNT_W-1:0]              pulses,
  output logic [ch_width(NUM_CH)-1:0]   ch_id,
  output logic                          meas_valid,
  output logic [NUM_CH-1:0]             echo_stuck,
  output logic [1:0]                    state
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  range_state_t       st;
  logic [CH_W-1:0]    cur_ch;
  logic [31:0]        cyc_cnt;
  logic [CNT_W-1:0]   echo_cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [NUM_CH-1:0]  echo_s;
  logic               cur_echo;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    us_echo_sync u_sync (
      .clk   (clk_50M),
      .reset (reset),
      .d     (echo_rx[i]),
      .q     (echo_s[i])
    );
  end

  assign cur_echo = echo_s[cur_ch];
  assign state    = st;

  // Saturating increment so a long or stuck echo never wraps back to small counts.
  always_comb begin
    cnt_next = echo_cnt;
    if (cur_echo && (echo_cnt != CNT_MAX))
      cnt_next = echo_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      st         <= WARM_UP;
      cur_ch     <= '0;
      cyc_cnt    <= '0;
      echo_cnt   <= '0;
      trigger    <= '0;
      out        <= '0;
      pulses     <= '0;
      ch_id      <= '0;
      meas_valid <= 1'b0;
      echo_stuck <= '0;
    end else begin
      meas_valid <= 1'b0;
      case (st)
        WARM_UP: begin
          if (!enable) begin
            cyc_cnt <= '0;
          end else if (cyc_cnt == 32'(WARM_CYC - 1)) begin
            cyc_cnt <= '0;
            trigger <= NUM_CH'(1) << cur_ch;
            st      <= TRIGGER;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end
        TRIGGER: begin
          if (cyc_cnt == 32'(TRIG_CYC - 1)) begin
            cyc_cnt  <= '0;
            trigger  <= '0;
            echo_cnt <= '0;
            st       <= MEASURE;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end
        MEASURE: begin
          echo_cnt <= cnt_next;
          // Results land with the strobe so they are valid throughout REPORT.
          if (cyc_cnt == 32'(MEAS_CYC - 1)) begin
            cyc_cnt            <= '0;
            pulses             <= cnt_next;
            ch_id              <= cur_ch;
            out[cur_ch]        <= (32'(cnt_next) >= 32'(THRESH));
            echo_stuck[cur_ch] <= cur_echo;
            meas_valid         <= 1'b1;
            st                 <= REPORT;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end
        REPORT: begin
          cur_ch <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
          st     <= WARM_UP;
        end
        default: st <= WARM_UP;
      endcase
    end
  end

endmodule

// File: tb/tb_us_multi_range_ctrl.sv
// Randomised bench for us_multi_range_ctrl using short timing parameters and a
// behavioural model of schedule, per-channel flags and saturating counts.
module tb_us_multi_range_ctrl;

  localparam int NUM_CH   = 4;
  localparam int WARM_CYC = 5;
  localparam int TRIG_CYC = 8;
  localparam int MEAS_CYC = 80;
  localparam int THRESH   = 40;
  localparam int CNT_W    = 6;
  localparam int PERIOD   = WARM_CYC + TRIG_CYC + MEAS_CYC + 1;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk_50M = 1'b0;
  logic              reset;
  logic              enable;
  logic [NUM_CH-1:0] echo_rx;
  logic [NUM_CH-1:0] trigger;
  logic [NUM_CH-1:0] out;
  logic [CNT_W-1:0]  pulses;
  logic [1:0]        ch_id;
  logic              meas_valid;
  logic [NUM_CH-1:0] echo_stuck;
  logic [1:0]        state;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int exp_ch = 0;
  int last_rise = 0;
  logic [NUM_CH-1:0] model_out = '0;
  logic [NUM_CH-1:0] model_stuck = '0;

  us_multi_range_ctrl #(
    .NUM_CH   (NUM_CH),
    .WARM_CYC (WARM_CYC),
    .TRIG_CYC (TRIG_CYC),
    .MEAS_CYC (MEAS_CYC),
    .THRESH   (THRESH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .enable     (enable),
    .echo_rx    (echo_rx),
    .trigger    (trigger),
    .out        (out),
    .pulses     (pulses),
    .ch_id      (ch_id),
    .meas_valid (meas_valid),
    .echo_stuck (echo_stuck),
    .state      (state)
  );

  always #10 clk_50M = ~clk_50M;

  // Free-running clock count used as the timebase for schedule checks.
  always @(posedge clk_50M) cyc <= cyc + 1;

  // One channel slot: mode 0 = echo pulse of len clocks after d clocks in the
  // window, mode 1 = echo held high across the whole window, mode 2 = silence.
  task automatic run_cycle(input int mode, input int d, input int len,
                           input int exp_rise, input bit drop_en, output int rise);
    int width;
    int exp_p;
    bit got;
    logic [NUM_CH-1:0] exp_trig;
    exp_trig = 4'b0001 << exp_ch;
    rise = -1;
    got = 0;
    for (int i = 0; i < 2 * PERIOD && !got; i++) begin
      @(negedge clk_50M);
      if (trigger !== '0) got = 1;
    end
    checks++;
    if (!got) begin
      $display("[TB] FAIL trigger_timeout ch%0d: no trigger within %0d clocks", exp_ch, 2 * PERIOD);
      return;
    end else passed++;
    rise = cyc;
    checks++;
    if (trigger !== exp_trig) $display("[TB] FAIL trigger_onehot: got %b want %b", trigger, exp_trig);
    else passed++;
    if (exp_rise >= 0) begin
      checks++;
      if (rise != exp_rise) $display("[TB] FAIL trigger_time ch%0d: got clock %0d want %0d", exp_ch, rise, exp_rise);
      else passed++;
    end
    if (drop_en) enable = 1'b0;
    if (mode == 1) echo_rx[exp_ch] = 1'b1;
    width = 0;
    while (trigger === exp_trig && width < 4 * TRIG_CYC) begin
      width++;
      @(negedge clk_50M);
    end
    checks++;
    if (width != TRIG_CYC) $display("[TB] FAIL trigger_width ch%0d: got %0d want %0d", exp_ch, width, TRIG_CYC);
    else passed++;
    if (mode == 0) begin
      repeat (d) @(negedge clk_50M);
      echo_rx[exp_ch] = 1'b1;
      repeat (len) @(negedge clk_50M);
      echo_rx[exp_ch] = 1'b0;
    end
    if (mode == 0)      exp_p = (len < CNT_MAX) ? len : CNT_MAX;
    else if (mode == 1) exp_p = (MEAS_CYC < CNT_MAX) ? MEAS_CYC : CNT_MAX;
    else                exp_p = 0;
    got = 0;
    for (int i = 0; i < MEAS_CYC + 10 && !got; i++) begin
      if (meas_valid === 1'b1) got = 1;
      else @(negedge clk_50M);
    end
    checks++;
    if (!got) begin
      $display("[TB] FAIL meas_valid_timeout ch%0d: strobe never seen", exp_ch);
      echo_rx = '0;
      return;
    end else passed++;
    model_out[exp_ch]   = (exp_p >= THRESH);
    model_stuck[exp_ch] = (mode == 1);
    checks++;
    if (pulses !== CNT_W'(exp_p)) $display("[TB] FAIL pulses ch%0d: got %0d want %0d", exp_ch, pulses, exp_p);
    else passed++;
    checks++;
    if (ch_id !== 2'(exp_ch)) $display("[TB] FAIL ch_id: got %0d want %0d", ch_id, exp_ch);
    else passed++;
    checks++;
    if (out !== model_out) $display("[TB] FAIL out ch%0d: got %b want %b", exp_ch, out, model_out);
    else passed++;
    checks++;
    if (echo_stuck !== model_stuck) $display("[TB] FAIL echo_stuck ch%0d: got %b want %b", exp_ch, echo_stuck, model_stuck);
    else passed++;
    checks++;
    if (state !== 2'b11) $display("[TB] FAIL report_state: got %0d want 3", state);
    else passed++;
    echo_rx[exp_ch] = 1'b0;
    @(negedge clk_50M);
    checks++;
    if (meas_valid !== 1'b0 || state !== 2'b00)
      $display("[TB] FAIL strobe_one_clock: got valid=%b state=%0d want valid=0 state=0", meas_valid, state);
    else passed++;
    exp_ch = (exp_ch + 1) % NUM_CH;
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    enable = 1'b0;
    echo_rx = '0;
    repeat (3) @(negedge clk_50M);
    checks++;
    if ({trigger, out, pulses, ch_id, meas_valid, echo_stuck, state} !== '0)
      $display("[TB] FAIL reset_outputs: got trig=%b out=%b pulses=%0d ch=%0d valid=%b stuck=%b state=%0d want all 0",
               trigger, out, pulses, ch_id, meas_valid, echo_stuck, state);
    else passed++;
    reset = 1'b0;
    ok = 1;
    repeat (3 * WARM_CYC) begin
      @(negedge clk_50M);
      if (state !== 2'b00 || trigger !== '0 || meas_valid !== 1'b0) ok = 0;
    end
    checks++;
    if (!ok) $display("[TB] FAIL enable_low_hold: got state=%0d trig=%b want 0 and 0", state, trigger);
    else passed++;
  endtask

  task automatic test_thresholds();
    int c0;
    enable = 1'b1;
    c0 = cyc;
    run_cycle(0, 5, 45, c0 + WARM_CYC, 0, last_rise);
    run_cycle(0, 3, THRESH - 1, last_rise + PERIOD, 0, last_rise);
    run_cycle(2, 0, 0, last_rise + PERIOD, 0, last_rise);
    run_cycle(1, 0, 0, last_rise + PERIOD, 0, last_rise);
    run_cycle(0, 2, 20, last_rise + PERIOD, 0, last_rise);
    run_cycle(0, 4, THRESH, last_rise + PERIOD, 0, last_rise);
  endtask

  task automatic test_random();
    int m, md, d, len;
    for (int k = 0; k < 8; k++) begin
      m = $urandom_range(0, 3);
      md = (m == 3) ? 1 : (m == 2) ? 2 : 0;
      d = $urandom_range(0, 10);
      len = $urandom_range(1, 74 - d);
      run_cycle(md, d, len, last_rise + PERIOD, 0, last_rise);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int c0;
    run_cycle(0, 1, 50, last_rise + PERIOD, 1, last_rise);
    ok = 1;
    repeat (2 * PERIOD) begin
      @(negedge clk_50M);
      if (state !== 2'b00 || trigger !== '0 || meas_valid !== 1'b0) ok = 0;
    end
    checks++;
    if (!ok) $display("[TB] FAIL enable_drop_park: got state=%0d trig=%b want 0 and 0", state, trigger);
    else passed++;
    enable = 1'b1;
    c0 = cyc;
    run_cycle(0, 6, 30, c0 + WARM_CYC, 0, last_rise);
  endtask

  task automatic test_reset_mid();
    bit got, ok;
    int c0;
    got = 0;
    for (int i = 0; i < 2 * PERIOD && !got; i++) begin
      @(negedge clk_50M);
      if (trigger !== '0) got = 1;
    end
    checks++;
    if (!got) $display("[TB] FAIL reset_mid_trigger_timeout: no trigger seen");
    else passed++;
    repeat (TRIG_CYC + 20) @(negedge clk_50M);
    echo_rx = 4'($urandom);
    reset = 1'b1;
    #1;
    checks++;
    if ({trigger, out, pulses, ch_id, meas_valid, echo_stuck, state} !== '0)
      $display("[TB] FAIL reset_mid_outputs: got trig=%b out=%b pulses=%0d valid=%b stuck=%b state=%0d want all 0",
               trigger, out, pulses, meas_valid, echo_stuck, state);
    else passed++;
    ok = 1;
    repeat (4) begin
      @(negedge clk_50M);
      if (meas_valid !== 1'b0 || trigger !== '0) ok = 0;
    end
    checks++;
    if (!ok) $display("[TB] FAIL reset_mid_quiet: got valid=%b trig=%b want 0", meas_valid, trigger);
    else passed++;
    echo_rx = '0;
    reset = 1'b0;
    exp_ch = 0;
    model_out = '0;
    model_stuck = '0;
    c0 = cyc;
    run_cycle(0, 0, 60, c0 + WARM_CYC, 0, last_rise);
    run_cycle(1, 0, 0, last_rise + PERIOD, 0, last_rise);
  endtask

  initial begin
    test_reset();
    test_thresholds();
    test_random();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
